// File: rtl/mx_mmu_pkg.sv
// Shared types and address constants for the MX memory pager.
package mx_mmu_pkg;

    typedef enum logic [1:0] {
        MODE_RAM  = 2'd0,
        MODE_DISK = 2'd1,
        MODE_ROM  = 2'd2
    } mode_t;

    // Legacy page port offsets (addr[1:0]); 2'b1x selects ROM.
    localparam logic [1:0] OFS_RAM  = 2'b00;
    localparam logic [1:0] OFS_DISK = 2'b01;

    localparam logic [15:0] DEF_PORT_BASE = 16'hFFFC;
    localparam logic [15:0] DEF_BANK_BASE = 16'hFFF4;
    localparam logic [15:0] DEF_SYS_BASE  = 16'hFFC0;

    // ROM overlay covers everything below this in MX ROM mode.
    localparam logic [15:0] ROM_TOP = 16'hC000;

endpackage

// File: rtl/mx_bank_regs.sv
// Per-window bank/write-protect register file: one write port, a map lookup
// port driven by the CPU window and a readback port driven by the bank port.
module mx_bank_regs #(
    parameter int BANK_BITS = 6,
    parameter int NUM_WIN   = 4,
    parameter int IW        = $clog2(NUM_WIN)
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [IW-1:0]        widx,
    input  logic [BANK_BITS-1:0] wbank,
    input  logic                 wwp,
    input  logic [IW-1:0]        map_idx,
    output logic [BANK_BITS-1:0] map_bank,
    output logic                 map_wp,
    input  logic [IW-1:0]        rd_idx,
    output logic [BANK_BITS-1:0] rd_bank,
    output logic                 rd_wp
);

    logic [NUM_WIN-1:0][BANK_BITS-1:0] bank;
    logic [NUM_WIN-1:0]                wp;

    // Window registers; reset gives the identity map with no protection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                bank[w] <= BANK_BITS'(w);
                wp[w]   <= 1'b0;
            end
        end else if (we) begin
            bank[widx] <= wbank;
            wp[widx]   <= wwp;
        end
    end

    assign map_bank = bank[map_idx];
    assign map_wp   = wp[map_idx];
    assign rd_bank  = bank[rd_idx];
    assign rd_wp    = wp[rd_idx];

endmodule

// File: rtl/mx_mem_pager.sv
// MX memory pager: page/bank port decode, write-edge detect, mode/disk state
// and the combinational CPU-to-SDRAM address mux with write protection.
module mx_mem_pager
    import mx_mmu_pkg::*;
#(
    parameter int          BANK_BITS = 6,
    parameter int          DISK_BITS = 3,
    parameter int          NUM_WIN   = 4,
    parameter logic [15:0] PORT_BASE = DEF_PORT_BASE,
    parameter logic [15:0] BANK_BASE = DEF_BANK_BASE,
    parameter logic [15:0] SYS_BASE  = DEF_SYS_BASE
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    mx,
    input  logic [15:0]             addr,
    input  logic [7:0]              din,
    input  logic                    wr_n,
    input  logic                    rd,
    output logic [BANK_BITS+13:0]   phys_addr,
    output logic                    rom_sel,
    output logic                    ram_we,
    output logic                    port_sel,
    output logic [7:0]              dout,
    output logic                    wp_fault
);

    localparam int PW = BANK_BITS + 14;
    localparam int DW = BANK_BITS - 2;   // disk page field above the 64KB offset

    if (DISK_BITS > BANK_BITS - 2 || (2 + (1 << DISK_BITS)) > (1 << (BANK_BITS - 2)))
    begin : g_bad_disk
        $error("mx_mem_pager: disk page does not fit in the physical address");
    end
    if (NUM_WIN != 4 || BANK_BITS > 7) begin : g_bad_win
        $error("mx_mem_pager: needs NUM_WIN == 4 and BANK_BITS <= 7");
    end

    mode_t                mode, mode_nxt;
    logic [DISK_BITS-1:0] disk, disk_nxt;
    logic                 wr_q;
    logic                 wr_evt;
    logic                 hit_port, hit_bank, is_sys, wp_hit;
    logic [BANK_BITS-1:0] map_bank, rd_bank;
    logic                 map_wp, rd_wp;
    logic                 din_unused;

    assign din_unused = &{1'b0, din};

    assign wr_evt   = wr_q & ~wr_n;
    assign hit_port = mx & (addr[15:2] == PORT_BASE[15:2]);
    assign hit_bank = mx & (addr[15:2] == BANK_BASE[15:2]);
    assign port_sel = hit_port | hit_bank;
    assign is_sys   = (addr >= SYS_BASE);

    mx_bank_regs #(.BANK_BITS(BANK_BITS), .NUM_WIN(NUM_WIN)) u_regs (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .we       (wr_evt & hit_bank),
        .widx     (addr[1:0]),
        .wbank    (din[BANK_BITS-1:0]),
        .wwp      (din[7]),
        .map_idx  (addr[15:14]),
        .map_bank (map_bank),
        .map_wp   (map_wp),
        .rd_idx   (addr[1:0]),
        .rd_bank  (rd_bank),
        .rd_wp    (rd_wp)
    );

    // Mode/disk state, write-strobe history and the protect fault pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mode     <= MODE_ROM;
            disk     <= '0;
            wr_q     <= 1'b1;
            wp_fault <= 1'b0;
        end else begin
            mode     <= mode_nxt;
            disk     <= disk_nxt;
            wr_q     <= wr_n;
            wp_fault <= wr_evt & wp_hit;
        end
    end

    // Next mode: legacy map auto-exits to RAM on any upper-half access;
    // the page port is only live in the MX map.
    always_comb begin
        mode_nxt = mode;
        disk_nxt = disk;
        if (!mx && addr[15]) begin
            mode_nxt = MODE_RAM;
        end else if (wr_evt && hit_port) begin
            case (addr[1:0])
                OFS_RAM:  mode_nxt = MODE_RAM;
                OFS_DISK: begin
                    mode_nxt = MODE_DISK;
                    disk_nxt = din[DISK_BITS-1:0];
                end
                default:  mode_nxt = MODE_ROM;
            endcase
        end
    end

    // Address mux; the system area above SYS_BASE is never paged.
    always_comb begin
        phys_addr = PW'(addr);
        rom_sel   = 1'b0;
        wp_hit    = 1'b0;
        if (!mx) begin
            rom_sel = (mode == MODE_ROM && addr[15:12] == 4'h0) || addr[15:12] == 4'hC;
        end else if (!is_sys) begin
            if (mode == MODE_ROM && addr < ROM_TOP) begin
                rom_sel = 1'b1;
            end else if (mode == MODE_DISK) begin
                phys_addr = {DW'(2) + DW'(disk), addr};
            end else begin
                phys_addr = {map_bank, addr[13:0]};
                wp_hit    = (mode == MODE_RAM) & map_wp;
            end
        end
    end

    assign ram_we = ~wr_n & ~rom_sel & ~port_sel & ~wp_hit;

    // Port readback; zero whenever the CPU is not reading a port.
    always_comb begin
        dout = 8'h00;
        if (rd && hit_bank)
            dout = {rd_wp, 7'(rd_bank)};
        else if (rd && hit_port)
            dout = {2'(mode), 3'b000, 3'(disk)};
    end

endmodule
